// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: takes one word per valid/ready handshake and
// shifts it out at a programmable bit period with frame, strobe and done marks.
module word_serializer #(
    parameter int WIDTH     = 16,
    parameter int DIV_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DIV_W-1:0] div_i,
    output logic             sdata_o,
    output logic             sstrobe_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Handshake: a word is accepted on a rising edge where valid_i and ready_o
    // are both high and rst_i is low; ready_o depends on the state flop only.
    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   shreg_q,   shreg_d;
    logic [DIV_W-1:0]   period_q,  period_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               sdata_q,   sdata_d;
    logic               sstrobe_q, sstrobe_d;
    logic               frame_q,   frame_d;
    logic               done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        period_d  = period_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shreg_d   = data_i;
                    period_d  = div_i;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_q == period_q) begin
                    div_cnt_d = '0;
                    shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg_q[WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with
        // the state they describe in the following cycle.
        frame_d   = (state_d == SHIFT);
        sdata_d   = frame_d & (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
        sstrobe_d = frame_d && (div_cnt_d == '0);
        done_d    = (state_q == SHIFT) && (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            period_q  <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sdata_q   <= 1'b0;
            sstrobe_q <= 1'b0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            period_q  <= period_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sdata_q   <= sdata_d;
            sstrobe_q <= sstrobe_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign sdata_o   = sdata_q;
    assign sstrobe_o = sstrobe_q;
    assign frame_o   = frame_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an MSB-first and an LSB-first instance
// share stimulus; expected serial bits come from a bench-side queue.
module tb_word_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] data_i = '0;
    logic [7:0]   div_i = '0;
    logic         valid_m = 1'b0;
    logic         valid_l = 1'b0;
    logic         sel_lsb = 1'b0;

    logic ready_m, sdata_m, sstrobe_m, frame_m, done_m;
    logic ready_l, sdata_l, sstrobe_l, frame_l, done_l;
    logic o_ready, o_sdata, o_sstrobe, o_frame, o_done;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_q[$];

    word_serializer #(.WIDTH(W), .DIV_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_m),
        .ready_o(ready_m), .div_i(div_i), .sdata_o(sdata_m),
        .sstrobe_o(sstrobe_m), .frame_o(frame_m), .done_o(done_m)
    );

    word_serializer #(.WIDTH(W), .DIV_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_l),
        .ready_o(ready_l), .div_i(div_i), .sdata_o(sdata_l),
        .sstrobe_o(sstrobe_l), .frame_o(frame_l), .done_o(done_l)
    );

    assign o_ready   = sel_lsb ? ready_l   : ready_m;
    assign o_sdata   = sel_lsb ? sdata_l   : sdata_m;
    assign o_sstrobe = sel_lsb ? sstrobe_l : sstrobe_m;
    assign o_frame   = sel_lsb ? frame_l   : frame_m;
    assign o_done    = sel_lsb ? done_l    : done_m;

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},   32'(o_ready),   32'd1);
        chk({tag, "_sdata"},   32'(o_sdata),   32'd0);
        chk({tag, "_frame"},   32'(o_frame),   32'd0);
        chk({tag, "_sstrobe"}, 32'(o_sstrobe), 32'd0);
        chk({tag, "_done"},    32'(o_done),    32'd0);
    endtask

    // driver: present a word at a negedge; accept happens on the next posedge
    task automatic drive_word(input logic [W-1:0] d, input logic [7:0] dv, input bit lsb);
        logic b;
        sel_lsb = lsb;
        data_i  = d;
        div_i   = dv;
        if (lsb) valid_l = 1'b1; else valid_m = 1'b1;
        for (int i = 0; i < W; i++) begin
            b = lsb ? d[i] : d[W-1-i];
            for (int j = 0; j <= int'(dv); j++) exp_q.push_back(b);
        end
    endtask

    // Checks every cycle of the word and the done cycle; leaves the bench at
    // the done-cycle negedge. data_i/div_i are scrambled mid-word.
    task automatic check_word(input logic [7:0] dv, input bit hold, input logic [W-1:0] nxt);
        int   n;
        logic eb;
        n = W * (int'(dv) + 1);
        @(negedge clk);
        data_i = nxt;
        div_i  = 8'd0;
        if (!hold) begin
            valid_m = 1'b0;
            valid_l = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            eb = exp_q.pop_front();
            chk("sdata",   32'(o_sdata),   32'(eb));
            chk("frame",   32'(o_frame),   32'd1);
            chk("sstrobe", 32'(o_sstrobe), 32'((c % (int'(dv) + 1)) == 0));
            chk("done_in_word", 32'(o_done), 32'd0);
            chk("ready_in_word", 32'(o_ready), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse",  32'(o_done),    32'd1);
        chk("done_frame",  32'(o_frame),   32'd0);
        chk("done_ready",  32'(o_ready),   32'd1);
        chk("done_sdata",  32'(o_sdata),   32'd0);
        chk("done_strobe", 32'(o_sstrobe), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic post_word();
        @(negedge clk);
        chk("done_width", 32'(o_done),  32'd0);
        chk("post_frame", 32'(o_frame), 32'd0);
        chk("post_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic         eb;
        logic         seen_done;
        logic [W-1:0] w;

        // reset with a handshake presented: must be discarded
        rst_i   = 1'b1;
        valid_m = 1'b1;
        data_i  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("reset");
        end
        rst_i   = 1'b0;
        valid_m = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // MSB-first, full rate
        drive_word(16'hA5C3, 8'd0, 1'b0);
        check_word(8'd0, 1'b0, 16'h5A3C);
        post_word();

        // divided rate; div_i forced to 0 mid-word must be ignored
        drive_word(16'h8001, 8'd3, 1'b0);
        check_word(8'd3, 1'b0, 16'h7FFE);
        post_word();

        // back-to-back with valid held high
        drive_word(16'hFFFF, 8'd0, 1'b0);
        check_word(8'd0, 1'b1, 16'h0000);
        drive_word(16'h0000, 8'd0, 1'b0);
        check_word(8'd0, 1'b0, 16'hFFFF);
        post_word();

        // reset pulse during bit 5 of 0x1234
        w = 16'h1234;
        drive_word(w, 8'd0, 1'b0);
        @(negedge clk);
        valid_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            eb = exp_q.pop_front();
            chk("abort_sdata", 32'(o_sdata), 32'(eb));
            chk("abort_frame", 32'(o_frame), 32'd1);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        chk_idle("abort");
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_done = seen_done | o_done;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        drive_word(16'h00FF, 8'd0, 1'b0);
        check_word(8'd0, 1'b0, 16'hAAAA);
        post_word();

        // LSB-first instance
        drive_word(16'h0001, 8'd1, 1'b1);
        check_word(8'd1, 1'b0, 16'hFFFF);
        post_word();

        // MSB-first instance stayed idle during the LSB word
        sel_lsb = 1'b0;
        chk_idle("msb_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial transmitter for the Redpitaya feedback datapath: the opposite end of our serial-to-parallel shift register. It accepts one WIDTH-bit word per valid/ready handshake, shifts it out one bit at a time at a programmable bit period, and marks each word with frame, per-bit strobe and end-of-word pulses. It sits between the sample/control logic and any serial link or bit-level consumer on the FPGA fabric.

## Interface
- WIDTH, 16, word length in bits; legal values are 2 and above.
- DIV_W, 8, width of the bit-period divider input.
- MSB_FIRST, 1, shift order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- Clock and reset: one clock; reset is synchronous and active-high.

Ports, in order:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- data_i  in  WIDTH  word to transmit; sampled only on accept.
- valid_i  in  1  word available on data_i.
- ready_o  out  1  block can accept a word; equals 1 exactly when the FSM is in IDLE.
- div_i  in  DIV_W  bit period minus 1, in clk_i cycles; sampled only on accept.
- sdata_o  out  1  serial data; registered.
- sstrobe_o  out  1  one-cycle pulse in the first cycle of every bit.
- frame_o  out  1  high for every cycle of a word.
- done_o  out  1  one-cycle pulse after the last bit of a word.

## Operation
- FSM states: IDLE and SHIFT.
- Accept condition: valid_i=1, ready_o=1 and rst_i=0 at a rising edge.
- On accept:
  - Load the shift register from data_i.
  - Load the period register from div_i.
  - Clear div_cnt (DIV_W bits) and bit_cnt (clog2(WIDTH) bits).
  - Go to SHIFT.
- SHIFT behaviour:
  - sdata_o drives the current head bit: shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - frame_o=1.
  - sstrobe_o=1 only when div_cnt=0.
  - div_cnt increments each cycle.
- When div_cnt equals the period register:
  - Clear div_cnt.
  - Shift the register by one position toward the head; fill with 0.
  - If bit_cnt = WIDTH-1, go to IDLE. Otherwise increment bit_cnt.
- First cycle back in IDLE: done_o=1, ready_o=1.
  - A new word may be accepted in this same cycle.
- IDLE outputs: sdata_o=0, frame_o=0, sstrobe_o=0.
- Changes on div_i or data_i during SHIFT are ignored.
- div_i=0 gives 1 cycle per bit. div_i=2^DIV_W-1 gives 2^DIV_W cycles per bit.
- Counters are unsigned and never exceed their limits. div_cnt wraps only through the explicit clear.

## Timing
- Reset values (in the cycle after any edge with rst_i=1):
  - FSM in IDLE; ready_o=1.
  - sdata_o=0, sstrobe_o=0, frame_o=0, done_o=0.
  - Shift register and counters are cleared.
- Handshakes presented while rst_i=1 are discarded.
- Accept at edge k:
  - Cycle k+1: frame_o=1, sstrobe_o=1, sdata_o = first bit.
  - Each bit is held for exactly div+1 cycles.
  - A word occupies cycles k+1 through k+WIDTH*(div+1).
  - Cycle k+WIDTH*(div+1)+1: done_o=1, frame_o=0, ready_o=1.
- Back-to-back operation (valid_i held high):
  - Between words, frame_o is low for exactly 1 cycle.
  - Peak throughput is one word per WIDTH*(div+1)+1 cycles.
- Reset mid-word:
  - The word is aborted immediately; all outputs take reset values on the next cycle.
  - No done_o is issued for the aborted word.
- ready_o is combinational from the state register only; there is no path from valid_i to ready_o.

## Test plan
- Reset check: hold rst_i for 3 cycles with valid_i=1 and data_i=0xFFFF -> nothing is accepted; ready_o=1, sdata_o=0, frame_o=0, sstrobe_o=0, done_o=0.
- MSB-first at full rate: WIDTH=16, MSB_FIRST=1, div_i=0, data 0xA5C3 -> sdata_o = 1010010111000011 over 16 cycles; sstrobe_o high every cycle; frame_o high for 16 cycles; done_o at the 17th cycle after accept.
- Divided rate with div_i ignored mid-word: div_i=3, data 0x8001; change div_i to 0 mid-word -> each bit lasts 4 cycles; sstrobe_o pulses every 4th cycle; frame_o high for 64 cycles; first and last 4-cycle bits are 1; done_o at cycle 65.
- Back-to-back: valid_i held high with words 0xFFFF then 0x0000, div_i=0 -> the second accept coincides with done_o; frame_o low for exactly 1 cycle between words; 16 ones followed by 16 zeros on sdata_o.
- Reset mid-word: rst_i pulsed for 1 cycle during bit 5 of 0x1234 -> next cycle frame_o=0 and sdata_o=0; no done_o; a following word 0x00FF is transmitted correctly.
- LSB-first: MSB_FIRST=0, data 0x0001, div_i=1 -> sdata_o is 1 for the first 2 cycles, then 0 for 30 cycles; done_o at cycle 33.
